// File: rtl/ikari_clk_pkg.sv
// ----------------------------------------------------------------------------
// ikari_clk_pkg
// Shared definitions for the clock-enable monitor blocks.
//   - mon_state_e : monitor FSM state encoding (IDLE / SYNC / MEASURE)
//   - MCLK_HZ     : system clock frequency (53.6 MHz)
//   - CEN_WINDOW_1MS and EXP_* : expected cen strobes per 1 ms window for
//     each clock-enable channel produced by the core generator.
// ----------------------------------------------------------------------------
package ikari_clk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_MEASURE = 2'd2
    } mon_state_e;

    localparam int unsigned MCLK_HZ        = 53600000;

    // One window = 1 ms of i_clk.
    localparam int unsigned CEN_WINDOW_1MS = 53600;

    // Expected strobes per CEN_WINDOW_1MS for each channel.
    localparam int unsigned EXP_13M4       = 13400;
    localparam int unsigned EXP_6M7        = 6700;
    localparam int unsigned EXP_3M35       = 3350;
    localparam int unsigned EXP_4M0        = 4000;

endpackage

// File: rtl/ikari_cen_gap_meter.sv
// ----------------------------------------------------------------------------
// ikari_cen_gap_meter
// Tracks the minimum and maximum spacing (in i_clk cycles) between
// consecutive cen strobes inside one measurement window. Spacing is
// window-local: a gap is only recorded when both strobes fall in the same
// window, so a window with fewer than two strobes reports min=all-ones,
// max=0.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : monitor not running; drop all tracking state
//   i_first        : first strobe of a measurement (opens the window)
//   i_cen          : strobe seen while measuring
//   i_wend         : last cycle of the window; latch results
//   o_gap_min      : min spacing of the last completed window
//   o_gap_max      : max spacing of the last completed window
// ----------------------------------------------------------------------------
module ikari_cen_gap_meter #(
    parameter int unsigned CW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_first,
    input  logic          i_cen,
    input  logic          i_wend,
    output logic [CW-1:0] o_gap_min,
    output logic [CW-1:0] o_gap_max
);

    localparam logic [CW-1:0] ONE = CW'(1);

    logic [CW-1:0] since_q;     // cycles since last strobe (== gap on next strobe)
    logic [CW-1:0] min_q;
    logic [CW-1:0] max_q;
    logic          have_q;      // a previous strobe exists in this window
    logic [CW-1:0] gap_min_q;
    logic [CW-1:0] gap_max_q;

    logic          gap_vld;
    logic [CW-1:0] cur_min;
    logic [CW-1:0] cur_max;

    assign gap_vld = i_cen && have_q;
    // Include this cycle's gap so the window-end strobe is not lost.
    assign cur_min = (gap_vld && (since_q < min_q)) ? since_q : min_q;
    assign cur_max = (gap_vld && (since_q > max_q)) ? since_q : max_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            since_q   <= '0;
            min_q     <= '1;
            max_q     <= '0;
            have_q    <= 1'b0;
            gap_min_q <= '0;
            gap_max_q <= '0;
        end else if (i_clr) begin
            since_q <= '0;
            min_q   <= '1;
            max_q   <= '0;
            have_q  <= 1'b0;
        end else begin
            if (i_wend) begin
                gap_min_q <= cur_min;
                gap_max_q <= cur_max;
                min_q     <= '1;
                max_q     <= '0;
                have_q    <= 1'b0;
            end else begin
                min_q <= cur_min;
                max_q <= cur_max;
                if (i_first || i_cen) begin
                    have_q <= 1'b1;
                end
            end

            if (i_first || i_cen) begin
                since_q <= ONE;
            end else if (since_q != '1) begin
                since_q <= since_q + ONE;
            end
        end
    end

    assign o_gap_min = gap_min_q;
    assign o_gap_max = gap_max_q;

endmodule

// File: rtl/ikari_cen_monitor.sv
// ----------------------------------------------------------------------------
// ikari_cen_monitor
// Consumer-side checker for one paired clock-enable channel (cen plus its
// 180-degree companion cenb). Counts cen strobes over a fixed window of
// i_clk cycles, flags frequency deviation and checks strict cen/cenb
// alternation.
//
// Optional feature: define CEN_MON_SPACING_EN to enable min/max cen-to-cen
// spacing tracking (o_gap_min / o_gap_max). Without it both are tied to 0.
//
// Ports:
//   i_clk       : system clock (53.6 MHz)
//   i_rst_n     : asynchronous active-low reset
//   i_en        : monitor enable; low returns the FSM to IDLE
//   i_cen       : clock-enable strobe under test
//   i_cenb      : 180-degree companion strobe
//   i_clr       : pulse, clears o_phase_err / o_err_cnt
//   o_count     : strobe count of last completed window
//   o_valid     : 1-cycle pulse when o_count / o_freq_ok update
//   o_freq_ok   : last window within EXP_COUNT +/- TOL
//   o_phase_err : sticky alternation-violation flag
//   o_err_cnt   : saturating alternation-violation count
//   o_gap_min   : min cen spacing, last window (feature build only)
//   o_gap_max   : max cen spacing, last window (feature build only)
// ----------------------------------------------------------------------------
module ikari_cen_monitor
    import ikari_clk_pkg::*;
#(
    parameter int unsigned WINDOW    = CEN_WINDOW_1MS,
    parameter int unsigned EXP_COUNT = EXP_13M4,
    parameter int unsigned TOL       = 2,
    parameter int unsigned CW        = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic          i_cen,
    input  logic          i_cenb,
    input  logic          i_clr,
    output logic [CW-1:0] o_count,
    output logic          o_valid,
    output logic          o_freq_ok,
    output logic          o_phase_err,
    output logic [7:0]    o_err_cnt,
    output logic [CW-1:0] o_gap_min,
    output logic [CW-1:0] o_gap_max
);

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW - 1);
    localparam logic [CW-1:0] EXP_C    = CW'(EXP_COUNT);
    localparam logic [CW:0]   TOL_C    = (CW+1)'(TOL);

    mon_state_e    state_q;
    logic [CW-1:0] win_cnt_q;   // index of the current cycle within the window
    logic [CW-1:0] str_cnt_q;   // strobes seen before the current cycle
    logic          pending_q;   // cen seen, matching cenb still owed
    logic [CW-1:0] count_q;
    logic          valid_q;
    logic          freq_ok_q;
    logic          phase_err_q;
    logic [7:0]    err_cnt_q;

    logic          cen_start;
    logic          measuring;
    logic          chk;
    logic          err;
    logic          win_end;
    logic [CW-1:0] str_inc;
    logic signed [CW:0] diff;
    logic [CW:0]   diff_abs;
    logic          freq_ok;

    // First strobe in SYNC opens the window (cycle 0) and is itself checked.
    assign cen_start = i_en && (state_q == ST_SYNC) && i_cen;
    assign measuring = i_en && (state_q == ST_MEASURE);
    assign chk       = cen_start || measuring;

    assign err = chk && ((i_cen && i_cenb) ||
                         (i_cen && pending_q) ||
                         (i_cenb && !pending_q));

    assign win_end = measuring && (win_cnt_q == WIN_LAST);

    // This cycle's strobe is counted, saturating at all-ones.
    assign str_inc = (i_cen && (str_cnt_q != '1)) ? (str_cnt_q + ONE) : str_cnt_q;

    // One extra bit keeps the signed difference from wrapping.
    assign diff     = $signed({1'b0, str_inc}) - $signed({1'b0, EXP_C});
    assign diff_abs = diff[CW] ? $unsigned(-diff) : $unsigned(diff);
    assign freq_ok  = (diff_abs <= TOL_C);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            win_cnt_q <= '0;
            str_cnt_q <= '0;
            pending_q <= 1'b0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            freq_ok_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!i_en) begin
                state_q   <= ST_IDLE;
                win_cnt_q <= '0;
                str_cnt_q <= '0;
                pending_q <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_SYNC;
                    end
                    ST_SYNC: begin
                        if (i_cen) begin
                            state_q   <= ST_MEASURE;
                            win_cnt_q <= ONE;
                            str_cnt_q <= ONE;
                            pending_q <= 1'b1;
                        end
                    end
                    ST_MEASURE: begin
                        if (win_end) begin
                            count_q   <= str_inc;
                            freq_ok_q <= freq_ok;
                            valid_q   <= 1'b1;
                            win_cnt_q <= '0;
                            str_cnt_q <= '0;
                        end else begin
                            win_cnt_q <= win_cnt_q + ONE;
                            str_cnt_q <= str_inc;
                        end
                        if (i_cen) begin
                            pending_q <= 1'b1;
                        end else if (i_cenb) begin
                            pending_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Sticky error state; an error in the same cycle as i_clr wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else if (err) begin
            phase_err_q <= 1'b1;
            if (i_clr) begin
                err_cnt_q <= 8'd1;
            end else if (err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end else if (i_clr) begin
            phase_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end
    end

    assign o_count     = count_q;
    assign o_valid     = valid_q;
    assign o_freq_ok   = freq_ok_q;
    assign o_phase_err = phase_err_q;
    assign o_err_cnt   = err_cnt_q;

`ifdef CEN_MON_SPACING_EN
    ikari_cen_gap_meter #(
        .CW (CW)
    ) u_gap_meter (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (!chk),
        .i_first   (cen_start),
        .i_cen     (measuring && i_cen),
        .i_wend    (win_end),
        .o_gap_min (o_gap_min),
        .o_gap_max (o_gap_max)
    );
`else
    assign o_gap_min = '0;
    assign o_gap_max = '0;
`endif

endmodule

// File: tb/tb_ikari_cen_monitor.sv
// ----------------------------------------------------------------------------
// tb_ikari_cen_monitor
// Self-checking bench for ikari_cen_monitor (WINDOW=16, EXP_COUNT=4, TOL=0).
// Stimulus pushes the expected window result (count, freq_ok, gaps and the
// cycle on which o_valid must be seen) into a scoreboard queue; a separate
// monitor pops and compares on every o_valid pulse.
// ----------------------------------------------------------------------------
module tb_ikari_cen_monitor;

    localparam int CW = 16;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          cen;
    logic          cenb;
    logic          clr;
    logic [CW-1:0] o_count;
    logic          o_valid;
    logic          o_freq_ok;
    logic          o_phase_err;
    logic [7:0]    o_err_cnt;
    logic [CW-1:0] o_gap_min;
    logic [CW-1:0] o_gap_max;

    ikari_cen_monitor #(
        .WINDOW    (16),
        .EXP_COUNT (4),
        .TOL       (0),
        .CW        (CW)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_cen       (cen),
        .i_cenb      (cenb),
        .i_clr       (clr),
        .o_count     (o_count),
        .o_valid     (o_valid),
        .o_freq_ok   (o_freq_ok),
        .o_phase_err (o_phase_err),
        .o_err_cnt   (o_err_cnt),
        .o_gap_min   (o_gap_min),
        .o_gap_max   (o_gap_max)
    );

    typedef struct {
        logic [CW-1:0] count;
        logic          ok;
        logic [CW-1:0] gmin;
        logic [CW-1:0] gmax;
        int            stamp;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected gap value: only meaningful when spacing tracking is built in.
    function automatic logic [CW-1:0] g(input logic [CW-1:0] v);
`ifdef CEN_MON_SPACING_EN
        return v;
`else
        return (v & '0);
`endif
    endfunction

    task automatic push(input int count, input logic ok, input int gmin, input int gmax, input int stamp);
        exp_t e;
        e.count = CW'(count);
        e.ok    = ok;
        e.gmin  = g(CW'(gmin));
        e.gmax  = g(CW'(gmax));
        e.stamp = stamp;
        sb_q.push_back(e);
    endtask

    // One clock cycle with the given strobes; inputs held across the edge.
    task automatic step(input logic c, input logic cb);
        cen  = c;
        cenb = cb;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run_pattern(input int period, input int off, input int n);
        for (int i = 0; i < n; i++) begin
            step((i % period) == 0, (i % period) == off);
        end
    endtask

    // Scoreboard monitor: sample on the falling edge, away from updates.
    always @(negedge clk) begin
        if (rst_n && o_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 32'(o_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("win_count",   32'(o_count),   32'(e.count));
                check("win_freq_ok", 32'(o_freq_ok), 32'(e.ok));
                check("win_gap_min", 32'(o_gap_min), 32'(e.gmin));
                check("win_gap_max", 32'(o_gap_max), 32'(e.gmax));
                check("win_cycle",   32'(cyc),       32'(e.stamp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_count"},     32'(o_count),     32'd0);
        check({tag, "_valid"},     32'(o_valid),     32'd0);
        check({tag, "_freq_ok"},   32'(o_freq_ok),   32'd0);
        check({tag, "_phase_err"}, 32'(o_phase_err), 32'd0);
        check({tag, "_err_cnt"},   32'(o_err_cnt),   32'd0);
        check({tag, "_gap_min"},   32'(o_gap_min),   32'd0);
        check({tag, "_gap_max"},   32'(o_gap_max),   32'd0);
    endtask

    initial begin
        int s;
        rst_n = 1'b0;
        en    = 1'b0;
        cen   = 1'b0;
        cenb  = 1'b0;
        clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        step(0, 0);

        // 1: nominal rate, cen every 4, cenb offset 2 -> three good windows.
        en = 1'b1;
        step(0, 0);
        s = cyc + 1;
        for (int k = 0; k < 3; k++) push(4, 1'b1, 4, 4, s + 15 + 16 * k);
        run_pattern(4, 2, 48);
        en = 1'b0;
        step(0, 0);
        check("t1_phase_err", 32'(o_phase_err), 32'd0);

        // 2: cen every 3, cenb offset 1 -> 6,5,5 strobes, out of tolerance.
        en = 1'b1;
        step(0, 0);
        s = cyc + 1;
        push(6, 1'b0, 3, 3, s + 15);
        push(5, 1'b0, 3, 3, s + 31);
        push(5, 1'b0, 3, 3, s + 47);
        run_pattern(3, 1, 48);
        en = 1'b0;
        step(0, 0);
        check("t2_phase_err", 32'(o_phase_err), 32'd0);
        check("t2_err_cnt",   32'(o_err_cnt),   32'd0);

        // 3: dropped cenb -> error on the following cen; i_clr clears it.
        en = 1'b1;
        step(0, 0);
        step(1, 0); step(0, 0); step(0, 1); step(0, 0);
        step(1, 0); step(0, 0); step(0, 0); step(0, 0);
        check("t3_pre_phase_err", 32'(o_phase_err), 32'd0);
        step(1, 0);
        check("t3_phase_err", 32'(o_phase_err), 32'd1);
        check("t3_err_cnt",   32'(o_err_cnt),   32'd1);
        clr = 1'b1;
        step(0, 0);
        clr = 1'b0;
        check("t3_clr_phase_err", 32'(o_phase_err), 32'd0);
        check("t3_clr_err_cnt",   32'(o_err_cnt),   32'd0);
        // Extra cenb with nothing pending is also a violation.
        step(0, 1);
        check("t3_cenb_ok", 32'(o_err_cnt), 32'd0);
        step(0, 1);
        check("t3_cenb_err", 32'(o_err_cnt), 32'd1);
        en  = 1'b0;
        clr = 1'b1;
        step(0, 0);
        clr = 1'b0;
        check("t3_end_err_cnt", 32'(o_err_cnt), 32'd0);

        // 4: cen+cenb together 300 times -> saturate at 255; clr loses to error.
        en = 1'b1;
        step(0, 0);
        s = cyc + 1;
        for (int k = 0; k < 18; k++) push(16, 1'b0, 1, 1, s + 15 + 16 * k);
        for (int i = 0; i < 300; i++) step(1, 1);
        check("t4_err_sat",   32'(o_err_cnt),   32'd255);
        check("t4_phase_err", 32'(o_phase_err), 32'd1);
        clr = 1'b1;
        step(1, 1);
        clr = 1'b0;
        check("t4_clr_err_wins_cnt", 32'(o_err_cnt),   32'd1);
        check("t4_clr_err_wins_flag", 32'(o_phase_err), 32'd1);
        en = 1'b0;
        step(0, 0);
        clr = 1'b1;
        step(0, 0);
        clr = 1'b0;
        check("t4_end_err_cnt", 32'(o_err_cnt), 32'd0);

        // 5: disable mid-window; count holds, new window starts from scratch.
        en = 1'b1;
        step(0, 0);
        s = cyc + 1;
        push(4, 1'b1, 4, 4, s + 15);
        run_pattern(4, 2, 24);
        en = 1'b0;
        step(0, 0); step(0, 0); step(0, 0);
        check("t5_count_hold", 32'(o_count),   32'd4);
        check("t5_ok_hold",    32'(o_freq_ok), 32'd1);
        en = 1'b1;
        step(0, 0); step(0, 0); step(0, 0);
        s = cyc + 1;
        push(4, 1'b1, 4, 4, s + 15);
        run_pattern(4, 2, 16);
        en = 1'b0;
        step(0, 0);

        // 6: cen gaps 3,5,4 inside one window -> min 3, max 5; reset mid-window.
        en = 1'b1;
        step(0, 0);
        s = cyc + 1;
        push(4, 1'b1, 3, 5, s + 15);
        for (int i = 0; i < 19; i++) begin
            step(i inside {0, 3, 8, 12, 16}, i inside {1, 5, 10, 14});
        end
        check("t6_count", 32'(o_count), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_rst");
        en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
